hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_control_unit_if.sv | 47 ++++
 rtl/hazard_fwd_sel.sv | 36 +++
 rtl/hazard_control_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: forwarding select codes,
// FSM state encoding, stall-cause codes and counter widths.
package hazard_pkg;

  // Forwarding mux select for an EX source operand
  localparam logic [1:0] FWD_REG = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // WB stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM stage result

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MSTALL = 2'd2
  } state_e;

  // stall_cause codes; 2'b11 is reserved and never produced
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_LOAD = 2'b01;
  localparam logic [1:0] CAUSE_MDU  = 2'b10;

  localparam int LCNT_W = 3;  // holds LOAD_LAT-1 for LOAD_LAT up to 7
  localparam int MCNT_W = 5;  // holds MDU_LAT up to 31

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of the pipeline-facing hazard signals.
//   master : pipeline side (drives stage info, receives control)
//   slave  : hazard unit side (receives stage info, drives control)
interface hazard_control_unit_if #(
  parameter int REG_AW = 5,
  parameter int NRP    = 2
);
  logic [NRP*REG_AW-1:0] id_src;
  logic [NRP-1:0]        id_src_used;
  logic                  id_mdu_start;
  logic                  id_uses_hilo;
  logic [NRP*REG_AW-1:0] ex_src;
  logic                  ex_memread;
  logic [REG_AW-1:0]     ex_dst;
  logic                  mem_regwrite;
  logic [REG_AW-1:0]     mem_dst;
  logic                  mem_memwrite;
  logic [REG_AW-1:0]     mem_rt;
  logic                  wb_regwrite;
  logic [REG_AW-1:0]     wb_dst;
  logic                  wb_memtoreg;
  logic                  branch_flush;
  logic [2*NRP-1:0]      fwd_ex;
  logic                  fwd_mem2mem;
  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  mdu_busy;
  logic [1:0]            stall_cause;

  modport master (
    output id_src, id_src_used, id_mdu_start, id_uses_hilo, ex_src, ex_memread,
           ex_dst, mem_regwrite, mem_dst, mem_memwrite, mem_rt, wb_regwrite,
           wb_dst, wb_memtoreg, branch_flush,
    input  fwd_ex, fwd_mem2mem, pc_en, ifid_en, ifid_flush, idex_bubble,
           mdu_busy, stall_cause
  );

  modport slave (
    input  id_src, id_src_used, id_mdu_start, id_uses_hilo, ex_src, ex_memread,
           ex_dst, mem_regwrite, mem_dst, mem_memwrite, mem_rt, wb_regwrite,
           wb_dst, wb_memtoreg, branch_flush,
    output fwd_ex, fwd_mem2mem, pc_en, ifid_en, ifid_flush, idex_bubble,
           mdu_busy, stall_cause
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-read-port comparisons: EX forwarding select and ID load-use match.
//   i_ex_src / i_id_src / i_id_used : operand of this port in EX and ID
//   i_mem_* / i_wb_*                : producers in MEM and WB
//   i_ex_dst                        : destination of the instruction in EX
//   o_fwd                           : forward select for this EX operand
//   o_lu_hit                        : ID operand matches EX destination
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_ex_src,
  input  logic [REG_AW-1:0] i_id_src,
  input  logic              i_id_used,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_wb_regwrite,
  input  logic [REG_AW-1:0] i_wb_dst,
  input  logic [REG_AW-1:0] i_ex_dst,
  output logic [1:0]        o_fwd,
  output logic              o_lu_hit
);

  // MEM is younger than WB, so its value wins; $zero is never forwarded
  always_comb begin
    o_fwd = FWD_REG;
    if (i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == i_ex_src))
      o_fwd = FWD_MEM;
    else if (i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == i_ex_src))
      o_fwd = FWD_WB;
  end

  // $zero / memread qualification is applied once in the top level
  assign o_lu_hit = i_id_used && (i_id_src == i_ex_dst);

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control for a 5-stage pipeline: operand forwarding, store-data
// forwarding, load-use stall, multiply/divide busy stall and branch flush.
//   clk, rst         : clock, synchronous active-high reset
//   id_*, ex_*, mem_*, wb_* : stage register numbers and control bits
//   branch_flush     : taken branch / jump resolved
//   fwd_ex           : 2-bit forward select per read port
//   fwd_mem2mem      : WB load data forwarded to the store in MEM
//   pc_en, ifid_en, ifid_flush, idex_bubble : pipeline control
//   mdu_busy         : multiply/divide unit busy
//   stall_cause      : 00 none, 01 load-use, 10 MDU
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NRP      = 2,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP*REG_AW-1:0] id_src,
  input  logic [NRP-1:0]        id_src_used,
  input  logic                  id_mdu_start,
  input  logic                  id_uses_hilo,
  input  logic [NRP*REG_AW-1:0] ex_src,
  input  logic                  ex_memread,
  input  logic [REG_AW-1:0]     ex_dst,
  input  logic                  mem_regwrite,
  input  logic [REG_AW-1:0]     mem_dst,
  input  logic                  mem_memwrite,
  input  logic [REG_AW-1:0]     mem_rt,
  input  logic                  wb_regwrite,
  input  logic [REG_AW-1:0]     wb_dst,
  input  logic                  wb_memtoreg,
  input  logic                  branch_flush,
  output logic [2*NRP-1:0]      fwd_ex,
  output logic                  fwd_mem2mem,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  mdu_busy,
  output logic [1:0]            stall_cause
);

  localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_LAT - 1);
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MDU_LAT);

  logic [2*NRP-1:0]  w_fwd;
  logic [NRP-1:0]    w_lu_hit;
  logic              w_load_use;
  logic              w_mdu_busy;
  logic              w_lu_stall;
  logic              w_mdu_stall;
  logic              w_mdu_go;
  logic [MCNT_W-1:0] w_mcnt_nxt;

  state_e            r_state;
  logic [LCNT_W-1:0] r_lcnt;
  logic [MCNT_W-1:0] r_mcnt;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
      .i_ex_src       (ex_src[p*REG_AW +: REG_AW]),
      .i_id_src       (id_src[p*REG_AW +: REG_AW]),
      .i_id_used      (id_src_used[p]),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_dst      (mem_dst),
      .i_wb_regwrite  (wb_regwrite),
      .i_wb_dst       (wb_dst),
      .i_ex_dst       (ex_dst),
      .o_fwd          (w_fwd[2*p +: 2]),
      .o_lu_hit       (w_lu_hit[p])
    );
  end

  assign w_load_use  = ex_memread && (ex_dst != '0) && (|w_lu_hit);
  assign w_mdu_busy  = (r_mcnt != '0);
  // The first load-use cycle stalls combinationally; LSTALL covers the rest
  assign w_lu_stall  = (r_state == LSTALL) || w_load_use;
  assign w_mdu_stall = w_mdu_busy && (id_uses_hilo || id_mdu_start);
  // A flushed ID instruction is squashed, so it must not launch the MDU
  assign w_mdu_go    = id_mdu_start && !w_mdu_busy && !w_lu_stall && !branch_flush;
  assign w_mcnt_nxt  = w_mdu_go   ? MCNT_INIT :
                       w_mdu_busy ? r_mcnt - 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_lcnt  <= '0;
      r_mcnt  <= '0;
    end else begin
      r_mcnt <= w_mcnt_nxt;
      if (branch_flush) begin
        // also drops a load-use seen this cycle: the load is being squashed
        r_state <= RUN;
        r_lcnt  <= '0;
      end else begin
        case (r_state)
          LSTALL: begin
            r_lcnt <= (r_lcnt != '0) ? r_lcnt - 1'b1 : '0;
            if (r_lcnt <= LCNT_W'(1))
              r_state <= (w_mdu_stall && (w_mcnt_nxt != '0)) ? MSTALL : RUN;
          end
          default: begin
            if (w_load_use && (LOAD_LAT > 1)) begin
              r_state <= LSTALL;
              r_lcnt  <= LCNT_INIT;
            end else if (w_mdu_stall && (w_mcnt_nxt != '0)) begin
              r_state <= MSTALL;
            end else begin
              r_state <= RUN;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    fwd_ex      = w_fwd;
    fwd_mem2mem = mem_memwrite && wb_memtoreg && (wb_dst != '0) && (wb_dst == mem_rt);
    mdu_busy    = w_mdu_busy;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_cause = CAUSE_NONE;
    if (rst) begin
      fwd_ex      = '0;
      fwd_mem2mem = 1'b0;
      mdu_busy    = 1'b0;
    end else if (branch_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_lu_stall || w_mdu_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      stall_cause = w_lu_stall ? CAUSE_LOAD : CAUSE_MDU;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Two instances share one stimulus: d1 with defaults, d3 with LOAD_LAT=3.
// Expected outputs come from a counter-based reference model of the rules.
module tb_hazard_control_unit;
  localparam int AW = 5;
  localparam int NP = 2;
  localparam int ML = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   lat [2];
  int   lrem[2], mrem[2], nl[2], nm[2];

  hazard_control_unit_if #(.REG_AW(AW), .NRP(NP)) hif ();
  hazard_control_unit_if #(.REG_AW(AW), .NRP(NP)) hif3 ();

  assign hif3.id_src       = hif.id_src;
  assign hif3.id_src_used  = hif.id_src_used;
  assign hif3.id_mdu_start = hif.id_mdu_start;
  assign hif3.id_uses_hilo = hif.id_uses_hilo;
  assign hif3.ex_src       = hif.ex_src;
  assign hif3.ex_memread   = hif.ex_memread;
  assign hif3.ex_dst       = hif.ex_dst;
  assign hif3.mem_regwrite = hif.mem_regwrite;
  assign hif3.mem_dst      = hif.mem_dst;
  assign hif3.mem_memwrite = hif.mem_memwrite;
  assign hif3.mem_rt       = hif.mem_rt;
  assign hif3.wb_regwrite  = hif.wb_regwrite;
  assign hif3.wb_dst       = hif.wb_dst;
  assign hif3.wb_memtoreg  = hif.wb_memtoreg;
  assign hif3.branch_flush = hif.branch_flush;

  hazard_control_unit #(.REG_AW(AW), .NRP(NP), .LOAD_LAT(1), .MDU_LAT(ML)) u_d1 (
    .clk(clk), .rst(rst),
    .id_src(hif.id_src), .id_src_used(hif.id_src_used),
    .id_mdu_start(hif.id_mdu_start), .id_uses_hilo(hif.id_uses_hilo),
    .ex_src(hif.ex_src), .ex_memread(hif.ex_memread), .ex_dst(hif.ex_dst),
    .mem_regwrite(hif.mem_regwrite), .mem_dst(hif.mem_dst),
    .mem_memwrite(hif.mem_memwrite), .mem_rt(hif.mem_rt),
    .wb_regwrite(hif.wb_regwrite), .wb_dst(hif.wb_dst),
    .wb_memtoreg(hif.wb_memtoreg), .branch_flush(hif.branch_flush),
    .fwd_ex(hif.fwd_ex), .fwd_mem2mem(hif.fwd_mem2mem), .pc_en(hif.pc_en),
    .ifid_en(hif.ifid_en), .ifid_flush(hif.ifid_flush),
    .idex_bubble(hif.idex_bubble), .mdu_busy(hif.mdu_busy),
    .stall_cause(hif.stall_cause)
  );

  hazard_control_unit #(.REG_AW(AW), .NRP(NP), .LOAD_LAT(3), .MDU_LAT(ML)) u_d3 (
    .clk(clk), .rst(rst),
    .id_src(hif3.id_src), .id_src_used(hif3.id_src_used),
    .id_mdu_start(hif3.id_mdu_start), .id_uses_hilo(hif3.id_uses_hilo),
    .ex_src(hif3.ex_src), .ex_memread(hif3.ex_memread), .ex_dst(hif3.ex_dst),
    .mem_regwrite(hif3.mem_regwrite), .mem_dst(hif3.mem_dst),
    .mem_memwrite(hif3.mem_memwrite), .mem_rt(hif3.mem_rt),
    .wb_regwrite(hif3.wb_regwrite), .wb_dst(hif3.wb_dst),
    .wb_memtoreg(hif3.wb_memtoreg), .branch_flush(hif3.branch_flush),
    .fwd_ex(hif3.fwd_ex), .fwd_mem2mem(hif3.fwd_mem2mem), .pc_en(hif3.pc_en),
    .ifid_en(hif3.ifid_en), .ifid_flush(hif3.ifid_flush),
    .idex_bubble(hif3.idex_bubble), .mdu_busy(hif3.mdu_busy),
    .stall_cause(hif3.stall_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] s);
    if (hif.mem_regwrite && hif.mem_dst != 0 && hif.mem_dst == s) return 2'b10;
    if (hif.wb_regwrite && hif.wb_dst != 0 && hif.wb_dst == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_load_use();
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NP; p++)
      if (hif.id_src_used[p] && hif.id_src[p*AW +: AW] == hif.ex_dst) hit = 1'b1;
    return hif.ex_memread && (hif.ex_dst != 0) && hit;
  endfunction

  // Compare one instance against the model and compute its next counts
  task automatic model_chk(input int k, input string pf,
                           input logic [3:0] fwd, input logic m2m, input logic pc,
                           input logic ife, input logic ifl, input logic bub,
                           input logic busy, input logic [1:0] cause);
    logic [3:0] e_fwd;
    logic e_m2m, e_pc, e_ife, e_ifl, e_bub, e_busy, lu_now, lu, mh, mbusy;
    logic [1:0] e_cause;
    mbusy  = mrem[k] > 0;
    lu_now = ref_load_use();
    lu     = (lrem[k] > 0) || lu_now;
    mh     = mbusy && (hif.id_uses_hilo || hif.id_mdu_start);
    e_pc = 1; e_ife = 1; e_ifl = 0; e_bub = 0; e_cause = 0;
    if (rst) begin
      e_fwd = 0; e_m2m = 0; e_busy = 0;
      nl[k] = 0; nm[k] = 0;
    end else begin
      e_fwd  = {ref_fwd(hif.ex_src[AW +: AW]), ref_fwd(hif.ex_src[0 +: AW])};
      e_m2m  = hif.mem_memwrite && hif.wb_memtoreg && hif.wb_dst != 0 && hif.wb_dst == hif.mem_rt;
      e_busy = mbusy;
      if (hif.branch_flush) begin
        e_ifl = 1; e_bub = 1;
      end else if (lu || mh) begin
        e_pc = 0; e_ife = 0; e_bub = 1; e_cause = lu ? 2'b01 : 2'b10;
      end
      nm[k] = (hif.id_mdu_start && !mbusy && !lu && !hif.branch_flush) ? ML :
              (mrem[k] > 0 ? mrem[k] - 1 : 0);
      if (hif.branch_flush)  nl[k] = 0;
      else if (lrem[k] > 0)  nl[k] = lrem[k] - 1;
      else if (lu_now)       nl[k] = lat[k] - 1;
      else                   nl[k] = 0;
    end
    chk({pf, ".fwd_ex"},      32'(fwd),   32'(e_fwd));
    chk({pf, ".fwd_mem2mem"}, 32'(m2m),   32'(e_m2m));
    chk({pf, ".pc_en"},       32'(pc),    32'(e_pc));
    chk({pf, ".ifid_en"},     32'(ife),   32'(e_ife));
    chk({pf, ".ifid_flush"},  32'(ifl),   32'(e_ifl));
    chk({pf, ".idex_bubble"}, 32'(bub),   32'(e_bub));
    chk({pf, ".mdu_busy"},    32'(busy),  32'(e_busy));
    chk({pf, ".stall_cause"}, 32'(cause), 32'(e_cause));
  endtask

  // Called right after a negedge with inputs applied
  task automatic step();
    #1;
    model_chk(0, "d1", hif.fwd_ex, hif.fwd_mem2mem, hif.pc_en, hif.ifid_en,
              hif.ifid_flush, hif.idex_bubble, hif.mdu_busy, hif.stall_cause);
    model_chk(1, "d3", hif3.fwd_ex, hif3.fwd_mem2mem, hif3.pc_en, hif3.ifid_en,
              hif3.ifid_flush, hif3.idex_bubble, hif3.mdu_busy, hif3.stall_cause);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      lrem[k] = nl[k];
      mrem[k] = nm[k];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0;
    hif.id_src = '0; hif.id_src_used = '0; hif.id_mdu_start = 0; hif.id_uses_hilo = 0;
    hif.ex_src = '0; hif.ex_memread = 0; hif.ex_dst = '0;
    hif.mem_regwrite = 0; hif.mem_dst = '0; hif.mem_memwrite = 0; hif.mem_rt = '0;
    hif.wb_regwrite = 0; hif.wb_dst = '0; hif.wb_memtoreg = 0; hif.branch_flush = 0;
  endtask

  function automatic logic [AW-1:0] rreg();
    return ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
  endfunction

  initial begin
    int low;
    n_chk = 0; n_err = 0;
    lat[0] = 1; lat[1] = 3;
    for (int k = 0; k < 2; k++) begin lrem[k] = 0; mrem[k] = 0; nl[k] = 0; nm[k] = 0; end
    idle();
    rst = 1;
    @(negedge clk);
    step(); step();
    rst = 0;
    step();

    // EX-EX forward, MEM wins over WB
    idle();
    hif.mem_regwrite = 1; hif.mem_dst = 8; hif.wb_regwrite = 1; hif.wb_dst = 8;
    hif.ex_src = {5'd0, 5'd8};
    #1; chk("exex", 32'(hif.fwd_ex), 32'(4'b0010));
    step();

    // $zero never forwards
    idle();
    hif.mem_regwrite = 1; hif.wb_regwrite = 1;
    #1; chk("zero", 32'(hif.fwd_ex), 32'(4'b0000));
    step();

    // Load-use on port 1, LOAD_LAT=3 -> three stall cycles
    idle();
    hif.ex_memread = 1; hif.ex_dst = 9; hif.id_src = {5'd9, 5'd0}; hif.id_src_used = 2'b10;
    low = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) idle();
      #1;
      if (hif3.pc_en == 1'b0) low++;
      if (i == 0) chk("lu3_cause", 32'(hif3.stall_cause), 32'(2'b01));
      step();
    end
    chk("lu3_len", 32'(low), 32'd3);

    // MDU start then HI/LO read held
    idle();
    hif.id_mdu_start = 1;
    step();
    hif.id_mdu_start = 0; hif.id_uses_hilo = 1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk("mdu_busy", 32'(hif.mdu_busy), (c <= 4) ? 32'd1 : 32'd0);
      chk("mdu_pc_en", 32'(hif.pc_en), (c <= 4) ? 32'd0 : 32'd1);
      step();
    end

    // Flush on the second load stall cycle
    idle();
    hif.ex_memread = 1; hif.ex_dst = 9; hif.id_src = {5'd9, 5'd0}; hif.id_src_used = 2'b10;
    step();
    idle(); hif.branch_flush = 1;
    #1;
    chk("fl_flush", 32'(hif3.ifid_flush), 32'd1);
    chk("fl_pc_en", 32'(hif3.pc_en), 32'd1);
    step();
    idle();
    #1; chk("fl_run", 32'(hif3.pc_en), 32'd1);
    step();

    // Reset while MDU busy
    idle(); hif.id_mdu_start = 1;
    step();
    hif.id_mdu_start = 0; hif.id_uses_hilo = 1;
    #1; chk("rs_busy_pre", 32'(hif.mdu_busy), 32'd1);
    step();
    rst = 1; hif.mem_regwrite = 1; hif.mem_dst = 3; hif.ex_src = {5'd0, 5'd3};
    #1;
    chk("rs_busy", 32'(hif.mdu_busy), 32'd0);
    chk("rs_fwd", 32'(hif.fwd_ex), 32'd0);
    chk("rs_pc_en", 32'(hif.pc_en), 32'd1);
    step();
    idle(); hif.id_uses_hilo = 1;
    #1;
    chk("rs_after_busy", 32'(hif.mdu_busy), 32'd0);
    chk("rs_after_pc", 32'(hif.pc_en), 32'd1);
    step();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      rst               = ($urandom_range(0, 49) == 0);
      hif.id_src        = {rreg(), rreg()};
      hif.id_src_used   = 2'($urandom_range(0, 3));
      hif.id_mdu_start  = ($urandom_range(0, 6) == 0);
      hif.id_uses_hilo  = ($urandom_range(0, 2) == 0);
      hif.ex_src        = {rreg(), rreg()};
      hif.ex_memread    = ($urandom_range(0, 2) == 0);
      hif.ex_dst        = rreg();
      hif.mem_regwrite  = 1'($urandom_range(0, 1));
      hif.mem_dst       = rreg();
      hif.mem_memwrite  = 1'($urandom_range(0, 1));
      hif.mem_rt        = rreg();
      hif.wb_regwrite   = 1'($urandom_range(0, 1));
      hif.wb_dst        = rreg();
      hif.wb_memtoreg   = 1'($urandom_range(0, 1));
      hif.branch_flush  = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
